key_debounce_fsm: RTL and testbench

- Debounces one raw active-low push-button and produces the debounced level `key_value` plus a one-cycle `key_flag` strobe on every debounced edge.
- Feeds the beeper toggle stage, which acts on `key_flag && key_value==0`.
- Also emits a one-shot long-press pulse for future UI stages.
- Sits between the board key pin and all key consumers.

---
 rtl/key_debounce_if.sv | 21 ++
 rtl/key_debounce_fsm.sv | 136 +++++++++++++
 tb/tb_key_debounce_fsm.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Raw key pin in, debounced level plus edge and long-press strobes out.
interface key_debounce_if;
  logic key;
  logic key_value;
  logic key_flag;
  logic long_press;

  modport master (
    output key,
    input  key_value,
    input  key_flag,
    input  long_press
  );

  modport slave (
    input  key,
    output key_value,
    output key_flag,
    output long_press
  );
endinterface

// File: rtl/key_debounce_fsm.sv
// Active-low push-button debouncer: two-flop synchroniser feeding a four-state FSM that
// publishes the debounced level, a one-cycle strobe per debounced edge and a one-shot long-press strobe.
module key_debounce_fsm #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LONG_CYC     = 50000000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_debounce_if.slave key_if
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
  // The strobe is registered, so it is launched one count before saturation.
  localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_CYC - 2);

  logic             s1_q;
  logic             key_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             key_value_q, key_value_d;
  logic             key_flag_q, key_flag_d;
  logic             long_press_q, long_press_d;
  logic             holding;
  logic             db_done;

  assign holding = (state_q == PRESSED) || (state_q == RELEASE_DB);
  assign db_done = (db_cnt_q == DB_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q         <= 1'b1;
      key_s_q      <= 1'b1;
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      key_value_q  <= 1'b1;
      key_flag_q   <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      s1_q         <= key_if.key;
      key_s_q      <= s1_q;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      key_value_q  <= key_value_d;
      key_flag_q   <= key_flag_d;
      long_press_q <= long_press_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (key_s_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s_q) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        // Release bounce returns to PRESSED without restarting the hold timer.
        if (!key_s_q) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (holding && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_d = hold_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    key_value_d  = key_value_q;
    key_flag_d   = 1'b0;
    long_press_d = 1'b0;
    case (state_q)
      PRESS_DB: begin
        if (!key_s_q && db_done) begin
          key_value_d = 1'b0;
          key_flag_d  = 1'b1;
        end
      end
      RELEASE_DB: begin
        if (key_s_q && db_done) begin
          key_value_d = 1'b1;
          key_flag_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (holding && (hold_cnt_q == HOLD_FIRE)) begin
      long_press_d = 1'b1;
    end
  end

  assign key_if.key_value  = key_value_q;
  assign key_if.key_flag   = key_flag_q;
  assign key_if.long_press = long_press_q;

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Bench for key_debounce_fsm: directed scenarios and random key activity against a run-length reference model.
module tb_key_debounce_fsm;
  localparam int DB = 4;
  localparam int LG = 20;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  key_debounce_if kif ();

  key_debounce_fsm #(
    .DEBOUNCE_CYC(DB),
    .LONG_CYC    (LG),
    .CNT_W       (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_if   (kif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: an edge is accepted once DB+1 consecutive synchronised samples
  // disagree with the current level; long press is scheduled LG-1 edges after acceptance.
  logic m_s1, m_ks, m_val, m_flag, m_long;
  int   m_run;
  int   m_long_at;
  int   cyc = 0;

  task automatic model_reset();
    m_s1 = 1'b1; m_ks = 1'b1; m_val = 1'b1;
    m_flag = 1'b0; m_long = 1'b0;
    m_run = 0; m_long_at = -1;
  endtask

  task automatic model_edge(input logic raw);
    logic smp;
    smp  = m_ks;
    m_ks = m_s1;
    m_s1 = raw;
    cyc++;
    m_flag = 1'b0;
    m_long = 1'b0;
    if (smp != m_val) m_run++;
    else m_run = 0;
    if (m_run == DB + 1) begin
      m_flag = 1'b1;
      m_val  = smp;
      m_run  = 0;
      if (smp == 1'b0) m_long_at = cyc + LG - 1;
      else if (cyc < m_long_at) m_long_at = -1;
    end
    if (cyc == m_long_at) begin
      m_long    = 1'b1;
      m_long_at = -1;
    end
  endtask

  function automatic logic [2:0] dut_out();
    return {kif.key_value, kif.key_flag, kif.long_press};
  endfunction

  function automatic logic [2:0] exp_out();
    return {m_val, m_flag, m_long};
  endfunction

  task automatic step(input logic k);
    kif.key = k;
    @(posedge sys_clk);
    #1;
    model_edge(k);
  endtask

  task automatic test_reset();
    kif.key   = 1'b1;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (dut_out() !== 3'b100) begin
      errors++;
      $display("FAIL reset_state got=%b exp=100", dut_out());
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL reset_idle_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_clean_press();
    int flag_at, nflag, nlong;
    flag_at = -1; nflag = 0; nlong = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL clean_press_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag) begin nflag++; flag_at = i; end
      if (kif.long_press) nlong++;
    end
    checks++;
    if (nflag != 1 || flag_at != DB + 2) begin
      errors++;
      $display("FAIL clean_press_flag got=%0d@%0d exp=1@%0d", nflag, flag_at, DB + 2);
    end
    checks++;
    if (nlong != 0) begin
      errors++;
      $display("FAIL clean_press_nolong got=%0d exp=0", nlong);
    end
    checks++;
    if (kif.key_value !== 1'b0) begin
      errors++;
      $display("FAIL clean_press_level got=%b exp=0", kif.key_value);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL clean_release_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_press_bounce();
    logic pat [0:4];
    int flag_at, nflag;
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    flag_at = -1; nflag = 0;
    for (int i = 0; i < 17; i++) begin
      step(i < 5 ? pat[i] : 1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL press_bounce_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag) begin nflag++; flag_at = i; end
    end
    checks++;
    if (nflag != 1 || flag_at != 5 + DB + 2) begin
      errors++;
      $display("FAIL press_bounce_flag got=%0d@%0d exp=1@%0d", nflag, flag_at, 5 + DB + 2);
    end
  endtask

  task automatic test_release_bounce();
    logic pat [0:2];
    int flag_at, nflag, early_hi;
    pat = '{1'b1, 1'b1, 1'b0};
    flag_at = -1; nflag = 0; early_hi = 0;
    for (int i = 0; i < 15; i++) begin
      step(i < 3 ? pat[i] : 1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL release_bounce_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag) begin nflag++; flag_at = i; end
      if (i < 3 + DB + 2 && kif.key_value !== 1'b0) early_hi++;
    end
    checks++;
    if (early_hi != 0) begin
      errors++;
      $display("FAIL release_bounce_hold got=%0d early-high cycles exp=0", early_hi);
    end
    checks++;
    if (nflag != 1 || flag_at != 3 + DB + 2 || kif.key_value !== 1'b1) begin
      errors++;
      $display("FAIL release_bounce_flag got=%0d@%0d val=%b exp=1@%0d val=1",
               nflag, flag_at, kif.key_value, 3 + DB + 2);
    end
  endtask

  task automatic test_long_press();
    int flag_at, nflag, long_at, nlong, rflag_at, nrflag;
    flag_at = -1; nflag = 0; long_at = -1; nlong = 0; rflag_at = -1; nrflag = 0;
    for (int i = 0; i < DB + 2 + 41; i++) begin
      step(1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL long_press_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag) begin nflag++; flag_at = i; end
      if (kif.long_press) begin nlong++; long_at = i; end
    end
    checks++;
    if (nflag != 1 || nlong != 1 || long_at - flag_at != LG - 1) begin
      errors++;
      $display("FAIL long_press_pulse got=flags%0d longs%0d gap%0d exp=flags1 longs1 gap%0d",
               nflag, nlong, long_at - flag_at, LG - 1);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL long_release_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag) begin nrflag++; rflag_at = i; end
    end
    checks++;
    if (nrflag != 1 || rflag_at != DB + 2 || kif.key_value !== 1'b1) begin
      errors++;
      $display("FAIL long_release_flag got=%0d@%0d exp=1@%0d", nrflag, rflag_at, DB + 2);
    end
  endtask

  // Release timed so its strobe lands on the same edge as the long-press strobe.
  task automatic test_flag_with_long();
    int both_at, rel_start;
    both_at = -1;
    rel_start = LG - 1;
    for (int i = 0; i < rel_start + 10; i++) begin
      step(i < rel_start ? 1'b0 : 1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL flag_with_long_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag && kif.long_press) both_at = i;
    end
    checks++;
    if (both_at != DB + 2 + LG - 1) begin
      errors++;
      $display("FAIL flag_with_long_coincide got=%0d exp=%0d", both_at, DB + 2 + LG - 1);
    end
  endtask

  task automatic test_reset_mid_press();
    int flag_at, nflag, rst_bad;
    flag_at = -1; nflag = 0; rst_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL rst_mid_pre_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    if (dut_out() !== 3'b100) rst_bad++;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      #1;
      if (dut_out() !== 3'b100) rst_bad++;
    end
    checks++;
    if (rst_bad != 0) begin
      errors++;
      $display("FAIL rst_mid_during got=%0d bad cycles exp=0", rst_bad);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL rst_mid_post_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (kif.key_flag) begin nflag++; flag_at = i; end
    end
    checks++;
    if (nflag != 1 || flag_at != DB + 2 || kif.key_value !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_flag got=%0d@%0d exp=1@%0d", nflag, flag_at, DB + 2);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL rst_mid_release_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step((i % 3 == 0) ? 1'b0 : 1'b1);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++;
        $display("FAIL glitch_model_cyc%0d got=%b exp=%b", i, dut_out(), exp_out());
      end
      if (dut_out() !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_quiet got=%0d disturbed cycles exp=0", bad);
    end
  endtask

  task automatic test_random();
    logic lvl;
    int   len, n, nflag;
    lvl = 1'b1; n = 0; nflag = 0;
    while (n < 900) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step(lvl);
        n++;
        checks++;
        if (dut_out() !== exp_out()) begin
          errors++;
          $display("FAIL random_cyc%0d got=%b exp=%b", n, dut_out(), exp_out());
        end
        if (kif.key_flag) nflag++;
      end
    end
    checks++;
    if (nflag == 0) begin
      errors++;
      $display("FAIL random_activity got=0 strobes exp=>0");
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_long_press();
    test_flag_with_long();
    test_reset_mid_press();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
